// File: rtl/program_loader.sv
// program_loader: writer side of program memory; assembles a big-endian byte stream
//    (16-bit word count N, then N 32-bit words) into one memory write per word.
// Latency: 4th byte of a word accepted -> WriteEnable high on the next cycle.
//    Done or Error follows the last write by one cycle.
// Backpressure: ByteReady drops during the WRITE cycle and in IDLE/DONE/ERROR.
//    Offered bytes are consumed only on ByteValid && ByteReady.
// Ports:
//    clk, reset (async active-low), Start (load pulse)
//    ByteIn/ByteValid/ByteReady (byte stream in)
//    WriteEnable/WriteAddress/WriteData (memory write port)
//    CpuHold/Done/Error (status)
// Optional: define PROGRAM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte
//    that is checked before Done.
module program_loader #(
   parameter int unsigned           MEMORY_DEPTH = 32,
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h00000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start,
   input  logic [7:0]            ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  WriteEnable,
   output logic [DATA_WIDTH-1:0] WriteAddress,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  CpuHold,
   output logic                  Done,
   output logic                  Error
);

   localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
      S_DONE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_ERROR,
      S_CHECK
`else
      S_ERROR
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic                    byte_ready_q, byte_ready_d;
   logic                    write_enable_q, write_enable_d;
   logic [DATA_WIDTH-1:0]   write_address_q, write_address_d;
   logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
   logic                    cpu_hold_q, cpu_hold_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic [15:0]             word_count_q, word_count_d;
   logic [1:0]              byte_idx_q, byte_idx_d;
   logic [IDX_W-1:0]        word_idx_q, word_idx_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]              csum_q, csum_d;
`endif

   logic                    byte_fire;
   logic [15:0]             len_full;
   logic [15:0]             next_idx;
   logic [DATA_WIDTH-1:0]   word_addr;

   assign byte_fire = ByteValid && byte_ready_q;
   // Full count as it stands when the low count byte is on the bus.
   assign len_full  = {word_count_q[15:8], ByteIn};
   assign next_idx  = 16'(word_idx_q) + 16'd1;
   // Wraps modulo 2^DATA_WIDTH by construction.
   assign word_addr = BASE_ADDRESS + (DATA_WIDTH'(word_idx_q) << 2);

   always_comb begin
      state_d         = state_q;
      byte_ready_d    = byte_ready_q;
      write_enable_d  = 1'b0;
      write_address_d = write_address_q;
      write_data_d    = write_data_q;
      cpu_hold_d      = cpu_hold_q;
      done_d          = done_q;
      error_d         = error_q;
      word_count_d    = word_count_q;
      byte_idx_d      = byte_idx_q;
      word_idx_d      = word_idx_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d          = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (Start) begin
               state_d      = S_LEN_HI;
               byte_ready_d = 1'b1;
               cpu_hold_d   = 1'b1;
               done_d       = 1'b0;
               error_d      = 1'b0;
               word_count_d = '0;
               byte_idx_d   = '0;
               word_idx_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d       = '0;
`endif
            end
         end
         S_LEN_HI: begin
            if (byte_fire) begin
               word_count_d[15:8] = ByteIn;
               state_d            = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (byte_fire) begin
               word_count_d = len_full;
               if (len_full == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  // An empty frame still carries a checksum byte (expected 00).
                  state_d      = S_CHECK;
`else
                  state_d      = S_DONE;
                  byte_ready_d = 1'b0;
                  cpu_hold_d   = 1'b0;
                  done_d       = 1'b1;
`endif
               end else if ({16'd0, len_full} > MEMORY_DEPTH) begin
                  // Oversized frame: rejected before any word is written.
                  state_d      = S_ERROR;
                  byte_ready_d = 1'b0;
                  cpu_hold_d   = 1'b0;
                  error_d      = 1'b1;
               end else begin
                  state_d      = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (byte_fire) begin
               write_data_d = {write_data_q[DATA_WIDTH-9:0], ByteIn};
               byte_idx_d   = byte_idx_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               csum_d       = csum_q ^ ByteIn;
`endif
               if (byte_idx_q == 2'd3) begin
                  state_d         = S_WRITE;
                  byte_ready_d    = 1'b0;
                  write_enable_d  = 1'b1;
                  write_address_d = word_addr;
               end
            end
         end
         S_WRITE: begin
            word_idx_d = word_idx_q + IDX_W'(1);
            if (next_idx == word_count_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_d      = S_CHECK;
               byte_ready_d = 1'b1;
`else
               state_d      = S_DONE;
               cpu_hold_d   = 1'b0;
               done_d       = 1'b1;
`endif
            end else begin
               state_d      = S_DATA;
               byte_ready_d = 1'b1;
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (byte_fire) begin
               byte_ready_d = 1'b0;
               cpu_hold_d   = 1'b0;
               // Words already written stay in memory either way.
               if (ByteIn == csum_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         byte_ready_q    <= 1'b0;
         write_enable_q  <= 1'b0;
         write_address_q <= BASE_ADDRESS;
         write_data_q    <= '0;
         cpu_hold_q      <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
         word_count_q    <= '0;
         byte_idx_q      <= '0;
         word_idx_q      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q          <= '0;
`endif
      end else begin
         state_q         <= state_d;
         byte_ready_q    <= byte_ready_d;
         write_enable_q  <= write_enable_d;
         write_address_q <= write_address_d;
         write_data_q    <= write_data_d;
         cpu_hold_q      <= cpu_hold_d;
         done_q          <= done_d;
         error_q         <= error_d;
         word_count_q    <= word_count_d;
         byte_idx_q      <= byte_idx_d;
         word_idx_q      <= word_idx_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum_q          <= csum_d;
`endif
      end
   end

   assign ByteReady    = byte_ready_q;
   assign WriteEnable  = write_enable_q;
   assign WriteAddress = write_address_q;
   assign WriteData    = write_data_q;
   assign CpuHold      = cpu_hold_q;
   assign Done         = done_q;
   assign Error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized frames against a word-level reference model.
// Latency: expected writes are queued at stimulus time and popped by a monitor.
// Backpressure: the byte driver holds each byte until ByteReady accepts it.
module tb_program_loader;

   localparam int DEPTH = 32;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Start = 1'b0;
   logic [7:0]  ByteIn = 8'h00;
   logic        ByteValid = 1'b0;
   logic        ByteReady;
   logic        WriteEnable;
   logic [31:0] WriteAddress;
   logic [31:0] WriteData;
   logic        CpuHold;
   logic        Done;
   logic        Error;

   program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .BASE_ADDRESS(32'h0)) dut (
      .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
      .ByteReady(ByteReady), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
      .WriteData(WriteData), .CpuHold(CpuHold), .Done(Done), .Error(Error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          last_we_cycle = 0;
   wr_t         wq[$];
   logic [31:0] words[0:255];

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (reset && WriteEnable) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", WriteAddress, WriteData);
         end else begin
            e = wq.pop_front();
            chk("write_addr", WriteAddress, e.addr);
            chk("write_data", WriteData, e.data);
            chk("hold_during_write", {31'd0, CpuHold}, 32'd1);
         end
         last_we_cycle = cycle;
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, {31'd0, ByteReady}, 32'd0);
      chk({tag, "_we"}, {31'd0, WriteEnable}, 32'd0);
      chk({tag, "_addr"}, WriteAddress, 32'h0);
      chk({tag, "_data"}, WriteData, 32'h0);
      chk({tag, "_hold"}, {31'd0, CpuHold}, 32'd0);
      chk({tag, "_done"}, {31'd0, Done}, 32'd0);
      chk({tag, "_error"}, {31'd0, Error}, 32'd0);
   endtask

   // mode 0: back-to-back, 1: one idle cycle before every byte, 2: random gaps
   task automatic send_byte(input logic [7:0] b, input int mode);
      int gap;
      gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin
         @(negedge clk);
         ByteValid = 1'b0;
         ByteIn    = 8'($urandom);
      end
      @(negedge clk);
      ByteValid = 1'b1;
      ByteIn    = b;
      for (int t = 0; t < 100; t++) begin
         if (ByteReady) begin
            @(posedge clk);
            return;
         end
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got ByteReady %b expected 1 within 100 cycles", ByteReady);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      ByteValid = 1'b0;
      Start     = 1'b1;
      @(negedge clk);
      Start     = 1'b0;
      chk("hold_after_start", {31'd0, CpuHold}, 32'd1);
      chk("done_cleared", {31'd0, Done}, 32'd0);
      chk("error_cleared", {31'd0, Error}, 32'd0);
   endtask

   // Reference: a frame of n words writes words[0..n-1] to 4*i when n fits,
   // nothing otherwise; it ends Done unless oversized or (checksum build) bad checksum.
   task automatic run_frame(input int n, input int mode, input bit bad);
      logic [7:0]  x;
      logic [15:0] n16;
      logic [31:0] w;
      bit          exp_done;
      bit          seen;
      x   = 8'h00;
      n16 = 16'(n);
      if (n <= DEPTH)
         for (int i = 0; i < n; i++) wq.push_back(wr_t'{addr: 32'(4 * i), data: words[i]});
      pulse_start();
      send_byte(n16[15:8], mode);
      send_byte(n16[7:0], mode);
      if (n <= DEPTH) begin
         for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) begin
               x = x ^ w[8*k +: 8];
               send_byte(w[8*k +: 8], mode);
            end
         end
         if (CSUM) send_byte(bad ? (x ^ 8'h01) : x, mode);
      end
      exp_done = (n <= DEPTH) && !(CSUM && bad);
      @(negedge clk);
      ByteValid = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 30; t++) begin
         if (Done || Error) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL frame_end_timeout: got Done %b Error %b expected one set within 30 cycles", Done, Error);
      end
      chk("frame_done", {31'd0, Done}, {31'd0, exp_done});
      chk("frame_error", {31'd0, Error}, {31'd0, !exp_done});
      chk("end_hold", {31'd0, CpuHold}, 32'd0);
      chk("end_ready", {31'd0, ByteReady}, 32'd0);
      chk("writes_outstanding", 32'(wq.size()), 32'd0);
      if (!CSUM && n >= 1 && n <= DEPTH)
         chk("done_after_last_write", 32'(cycle - last_we_cycle), 32'd1);
      wq.delete();
   endtask

   initial begin
      int n;
      int r;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b1;

      words[0] = 32'h20080005;
      words[1] = 32'h01095020;
      run_frame(2, 0, 1'b0);
      run_frame(0, 0, 1'b0);
      run_frame(33, 0, 1'b0);
      words[0] = $urandom;
      run_frame(1, 1, 1'b0);

      // Reset three bytes into the second word: first write stays done, rest abandoned.
      words[0] = $urandom;
      words[1] = $urandom;
      wq.push_back(wr_t'{addr: 32'h0, data: words[0]});
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      for (int k = 3; k >= 0; k--) send_byte(words[0][8*k +: 8], 0);
      for (int k = 3; k >= 1; k--) send_byte(words[1][8*k +: 8], 0);
      #2 reset = 1'b0;
      #1 check_reset_vals("midload_reset");
      chk("midload_first_write", 32'(wq.size()), 32'd0);
      wq.delete();
      @(negedge clk);
      ByteValid = 1'b0;
      reset     = 1'b1;
      for (int i = 0; i < 3; i++) words[i] = $urandom;
      run_frame(3, 2, 1'b0);

      if (CSUM) begin
         words[0] = 32'h11223344;
         run_frame(1, 0, 1'b0);
         run_frame(1, 0, 1'b1);
      end

      for (int it = 0; it < 12; it++) begin
         r = int'($urandom_range(0, 9));
         n = (r == 0) ? DEPTH : (r == 1) ? DEPTH + 1 + int'($urandom_range(0, 200)) : int'($urandom_range(0, 5));
         for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
         run_frame(n, int'($urandom_range(0, 2)), CSUM ? 1'($urandom_range(0, 1)) : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
